riscv_data_mem_resp: RTL and testbench

- Responder end of the CPU data-memory port: accepts data_rden/data_wren requests with data_add/data_o from the core.
- Returns read data on data_i with the data_av/mem_busy handshake.
- Backed by an internal word-addressed synchronous RAM with a programmable wait-state count, so the core's stall logic can be exercised.
- Sits between riscv_cpu_no and the system bus/testbench. Full-word only: sub-word stores reach it as read-then-write pairs already merged by the core.

---
 rtl/riscv_mem_pkg.sv | 8 +
 rtl/riscv_sram_1p.sv | 19 +
 rtl/riscv_data_mem_resp.sv | 79 +++++++
 tb/tb_riscv_data_mem_resp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state type, data width and address range check for the data-memory responder
package riscv_mem_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RD_DONE} mem_resp_state_t;
  function automatic logic in_range(input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] base, input int unsigned depth);
    return (addr >= base) && ((addr - base) < (DATA_W'(depth) << 2));
  endfunction
endpackage

// File: rtl/riscv_sram_1p.sv
// riscv_sram_1p: single-port sync RAM, one read or write per enabled edge, registered read (clk_i, en_i, we_i, addr_i, wdata_i -> rdata_o)
module riscv_sram_1p import riscv_mem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else rdata_o <= mem[addr_i];
    end
endmodule

// File: rtl/riscv_data_mem_resp.sv
// riscv_data_mem_resp: data-memory responder with wait states; clk_i/rst_ni/mem_clken_i, core request (data_add_i, data_wdata_i, data_rden_i, data_wren_i) -> data_rdata_o, data_av_o, mem_busy_o, err_o, req_count_o
module riscv_data_mem_resp import riscv_mem_pkg::*; #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RD_ERR_DATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_clken_i,
  input  logic [31:0] data_add_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_rden_i,
  input  logic        data_wren_i,
  output logic [31:0] data_rdata_o,
  output logic        data_av_o,
  output logic        mem_busy_o,
  output logic        err_o,
  output logic [31:0] req_count_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);
  localparam logic ZERO_WS = (WAIT_STATES == 0);
  mem_resp_state_t state, state_n;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, rd_hold, ram_q, cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  logic rd_oor, acc, wr_acc, rd_acc, wr_now, rd_now, inr, ram_en;
  always_comb begin
    acc = state == IDLE || state == RD_DONE;
    wr_acc = acc && data_wren_i;
    rd_acc = acc && data_rden_i && !data_wren_i;
    wr_now = (wr_acc && ZERO_WS) || (state == WR_WAIT && cnt == '0);
    rd_now = (rd_acc && ZERO_WS) || (state == RD_WAIT && cnt == '0);
    cur_addr = acc ? data_add_i : addr_q;
    cur_wdata = acc ? data_wdata_i : wdata_q;
    idx = AW'((cur_addr - BASE_ADDR) >> 2);
    inr = in_range(cur_addr, BASE_ADDR, DEPTH_WORDS);
    ram_en = rst_ni && mem_clken_i && (wr_now || rd_now) && inr;
    state_n = wr_acc ? (ZERO_WS ? IDLE : WR_WAIT)
            : rd_acc ? (ZERO_WS ? RD_DONE : RD_WAIT)
            : acc ? IDLE
            : cnt != '0 ? state
            : state == RD_WAIT ? RD_DONE : IDLE;
  end
  riscv_sram_1p #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (wr_now),
    .addr_i (idx),
    .wdata_i(cur_wdata),
    .rdata_o(ram_q)
  );
  assign data_av_o = state == RD_DONE;
  assign mem_busy_o = state == RD_WAIT || state == WR_WAIT;
  assign data_rdata_o = state == RD_DONE ? (rd_oor ? RD_ERR_DATA : ram_q) : rd_hold;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_hold <= '0;
      rd_oor <= 1'b0;
      err_o <= 1'b0;
      req_count_o <= '0;
    end else if (mem_clken_i) begin
      state <= state_n;
      cnt <= (wr_acc || rd_acc) ? WS_INIT : cnt != '0 ? cnt - 4'd1 : cnt;
      if (wr_acc || rd_acc) begin
        addr_q <= data_add_i;
        wdata_q <= data_wdata_i;
        req_count_o <= req_count_o + 32'd1;
      end
      if (rd_now) rd_oor <= !inr;
      if (state == RD_DONE) rd_hold <= data_rdata_o;
      err_o <= (wr_acc && data_rden_i) || ((wr_now || rd_now) && !inr);
    end
endmodule

// File: tb/tb_riscv_data_mem_resp.sv
// tb_riscv_data_mem_resp: directed checks of the responder with zero and three wait states
module tb_riscv_data_mem_resp;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic clken = 1'b1;
  logic sel = 1'b0;
  logic rden = 1'b0;
  logic wren = 1'b0;
  logic [31:0] add = '0;
  logic [31:0] wdata = '0;
  logic [31:0] d;
  logic [31:0] rdata0, rdata3, cnt0, cnt3;
  logic av0, av3, busy0, busy3, err0, err3;
  int n_chk = 0;
  int n_pass = 0;
  wire av_s = sel ? av3 : av0;
  wire busy_s = sel ? busy3 : busy0;
  wire [31:0] rdata_s = sel ? rdata3 : rdata0;
  always #5 clk_i = ~clk_i;
  riscv_data_mem_resp #(.RD_ERR_DATA(32'hDEAD_BEEF)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_clken_i(clken),
    .data_add_i(add), .data_wdata_i(wdata),
    .data_rden_i(rden && !sel), .data_wren_i(wren && !sel),
    .data_rdata_o(rdata0), .data_av_o(av0), .mem_busy_o(busy0),
    .err_o(err0), .req_count_o(cnt0)
  );
  riscv_data_mem_resp #(.WAIT_STATES(3), .RD_ERR_DATA(32'hDEAD_BEEF)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_clken_i(clken),
    .data_add_i(add), .data_wdata_i(wdata),
    .data_rden_i(rden && sel), .data_wren_i(wren && sel),
    .data_rdata_o(rdata3), .data_av_o(av3), .mem_busy_o(busy3),
    .err_o(err3), .req_count_o(cnt3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    add = a;
    wdata = v;
    wren = 1'b1;
    tick;
    wren = 1'b0;
    for (int i = 0; i < 20 && busy_s; i++) tick;
    chk("wr_done", busy_s, 0);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    add = a;
    rden = 1'b1;
    tick;
    rden = 1'b0;
    for (int i = 0; i < 20 && !av_s; i++) tick;
    chk("rd_av", av_s, 1);
    q = rdata_s;
    tick;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk("rst_rdata", rdata0, 0);
    chk("rst_av", av0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_err", err0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_count3", cnt3, 0);
    sel = 1'b0;
    add = 32'h2004;
    wdata = 32'hCAFE_BABE;
    wren = 1'b1;
    tick;
    wren = 1'b0;
    chk("ws0_wr_busy", busy0, 0);
    rden = 1'b1;
    tick;
    rden = 1'b0;
    chk("ws0_rd_av", av0, 1);
    chk("ws0_rd_data", rdata0, 32'hCAFE_BABE);
    chk("ws0_rd_busy", busy0, 0);
    chk("ws0_count", cnt0, 2);
    tick;
    chk("ws0_av_pulse", av0, 0);
    chk("ws0_rd_hold", rdata0, 32'hCAFE_BABE);
    sel = 1'b1;
    add = 32'h2008;
    rden = 1'b1;
    tick;
    chk("ws3_busy1", busy3, 1);
    chk("ws3_av1", av3, 0);
    tick;
    chk("ws3_busy2", busy3, 1);
    tick;
    chk("ws3_busy3", busy3, 1);
    rden = 1'b0;
    tick;
    chk("ws3_av4", av3, 1);
    chk("ws3_busy4", busy3, 0);
    chk("ws3_count", cnt3, 1);
    tick;
    chk("ws3_av_pulse", av3, 0);
    sel = 1'b0;
    wr(32'h2000, 32'hAABB_CCDD);
    add = 32'h1FFC;
    rden = 1'b1;
    tick;
    rden = 1'b0;
    chk("oor_rd_av", av0, 1);
    chk("oor_rd_data", rdata0, 32'hDEAD_BEEF);
    chk("oor_rd_err", err0, 1);
    tick;
    chk("oor_rd_err_pulse", err0, 0);
    add = 32'h3000;
    wdata = 32'h1111_1111;
    wren = 1'b1;
    tick;
    wren = 1'b0;
    chk("oor_wr_err", err0, 1);
    tick;
    chk("oor_wr_err_pulse", err0, 0);
    rd(32'h2000, d);
    chk("oor_wr_word0", d, 32'hAABB_CCDD);
    add = 32'h2010;
    wdata = 32'h1234_5678;
    rden = 1'b1;
    wren = 1'b1;
    tick;
    rden = 1'b0;
    wren = 1'b0;
    chk("both_err", err0, 1);
    chk("both_av", av0, 0);
    tick;
    chk("both_av_next", av0, 0);
    chk("both_err_pulse", err0, 0);
    rd(32'h2010, d);
    chk("both_readback", d, 32'h1234_5678);
    rd(32'h2000, d);
    chk("sub_old", d, 32'hAABB_CCDD);
    wr(32'h2000, 32'hAABB_CC11);
    rd(32'h2000, d);
    chk("sub_merged", d, 32'hAABB_CC11);
    sel = 1'b1;
    wr(32'h2004, 32'h55AA_55AA);
    add = 32'h2004;
    rden = 1'b1;
    tick;
    rden = 1'b0;
    tick;
    clken = 1'b0;
    tick;
    chk("frz_av1", av3, 0);
    chk("frz_busy1", busy3, 1);
    tick;
    chk("frz_av2", av3, 0);
    chk("frz_busy2", busy3, 1);
    clken = 1'b1;
    tick;
    chk("frz_av3", av3, 0);
    tick;
    chk("frz_av4", av3, 1);
    chk("frz_data", rdata3, 32'h55AA_55AA);
    tick;
    add = 32'h2004;
    wdata = 32'h0BAD_F00D;
    wren = 1'b1;
    tick;
    wren = 1'b0;
    chk("rst_wr_busy", busy3, 1);
    tick;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_busy", busy3, 0);
    chk("rst_mid_av", av3, 0);
    chk("rst_mid_err", err3, 0);
    chk("rst_mid_count", cnt3, 0);
    chk("rst_mid_rdata", rdata3, 0);
    tick;
    rst_ni = 1'b1;
    tick;
    rd(32'h2004, d);
    chk("rst_mid_word", d, 32'h55AA_55AA);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
